// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes decoded by the control path and the
// execute-stage state encoding.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 3;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_MUL = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, product mod 2^XLEN.
// done_o/product_o are combinational so the caller can capture the product on the final iteration edge.
module alu_mul_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CW'(XLEN - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with valid/ready handshakes on input and output.
// Optional iterative multiply (code 100) is enabled by defining ALU_EXEC_MUL_EN.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [XLEN-1:0]       src_a,
  input  logic [XLEN-1:0]       src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic                  zero,
  output logic                  illegal
);

  alu_state_e      state_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;

  logic [XLEN-1:0] result_d;
  logic            zero_d;
  logic            illegal_d;
  logic            is_mul_d;
  logic            accept;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  always_comb begin
    result_d  = '0;
    illegal_d = 1'b0;
    is_mul_d  = 1'b0;
    case (alu_ctrl_e'(alu_control))
      ALU_ADD: result_d = src_a + src_b;
      ALU_SUB: result_d = src_a - src_b;
      ALU_AND: result_d = src_a & src_b;
      ALU_OR:  result_d = src_a | src_b;
      ALU_SLT: result_d = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_EXEC_MUL_EN
      ALU_MUL: is_mul_d = 1'b1;
`endif
      default: illegal_d = 1'b1;
    endcase
    zero_d = (result_d == '0);
  end

`ifdef ALU_EXEC_MUL_EN
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  alu_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (accept && is_mul_d),
    .a_i       (src_a),
    .b_i       (src_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
`ifdef ALU_EXEC_MUL_EN
        // Product is captured on the edge that performs the last iteration.
        MUL: begin
          if (mul_done) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            result_q    <= mul_product;
            zero_q      <= (mul_product == '0);
            illegal_q   <= 1'b0;
          end
        end
`endif
        default: begin
          if (accept && is_mul_d) begin
            state_q     <= MUL;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; multiply scenarios depend on ALU_EXEC_MUL_EN.
module tb_alu_exec_unit;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int tests;
  int fails;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    in_valid    = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = '0; src_a = '0; src_b = '0;
    step(); step();
    rst = 1'b0;
    tests++;
    if ({out_valid, result, zero, illegal, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset: got ov=%b res=%h z=%b ill=%b rdy=%b, exp ov=0 res=0 z=0 ill=0 rdy=1",
               out_valid, result, zero, illegal, in_ready);
    end
  endtask

  task automatic test_add();
    issue(3'b000, 32'h5, 32'h3);
    step();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, result, zero, illegal} !== {1'b1, 32'h8, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL add: got ov=%b res=%h z=%b ill=%b, exp ov=1 res=00000008 z=0 ill=0",
               out_valid, result, zero, illegal);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_drain: got out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_sub_slt();
    issue(3'b001, 32'h1234_5678, 32'h1234_5678);
    step();
    tests++;
    if ({out_valid, result, zero} !== {1'b1, 32'h0, 1'b1}) begin
      fails++;
      $display("FAIL sub_eq: got ov=%b res=%h z=%b, exp ov=1 res=0 z=1", out_valid, result, zero);
    end
    issue(3'b101, 32'hFFFF_FFFF, 32'h1);
    step();
    tests++;
    if ({out_valid, result, zero} !== {1'b1, 32'h1, 1'b0}) begin
      fails++;
      $display("FAIL slt_neg: got ov=%b res=%h z=%b, exp ov=1 res=1 z=0", out_valid, result, zero);
    end
    issue(3'b101, 32'h1, 32'hFFFF_FFFF);
    step();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, result, zero} !== {1'b1, 32'h0, 1'b1}) begin
      fails++;
      $display("FAIL slt_pos: got ov=%b res=%h z=%b, exp ov=1 res=0 z=1", out_valid, result, zero);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [2:0]      ops [4] = '{3'b000, 3'b011, 3'b001, 3'b010};
    logic [XLEN-1:0] as  [4] = '{32'd10, 32'h0F, 32'd5, 32'hFF};
    logic [XLEN-1:0] bs  [4] = '{32'd20, 32'hF0, 32'd7, 32'h0F};
    logic [XLEN-1:0] exp [4] = '{32'd30, 32'hFF, 32'hFFFF_FFFE, 32'h0F};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      step();
      tests++;
      if (out_valid !== 1'b1 || result !== exp[i]) begin
        fails++;
        $display("FAIL b2b_%0d: got ov=%b res=%h, exp ov=1 res=%h", i, out_valid, result, exp[i]);
      end
    end
    in_valid = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end: got out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step();
    issue(3'b000, 32'h1, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({in_ready, out_valid, result} !== {1'b0, 1'b1, 32'hF000_F000}) begin
        fails++;
        $display("FAIL bp_hold_%0d: got rdy=%b ov=%b res=%h, exp rdy=0 ov=1 res=f000f000",
                 i, in_ready, out_valid, result);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready: got in_ready=%b exp 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, result} !== {1'b1, 32'h2}) begin
      fails++;
      $display("FAIL bp_swap: got ov=%b res=%h, exp ov=1 res=00000002", out_valid, result);
    end
    step();
  endtask

  task automatic test_illegal();
    logic [2:0] codes [3] = '{3'b111, 3'b110, 3'b100};
    int n = 2;
`ifndef ALU_EXEC_MUL_EN
    n = 3;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      issue(codes[i], 32'h5, 32'h5);
      step();
      tests++;
      if ({out_valid, result, zero, illegal} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
        fails++;
        $display("FAIL illegal_%b: got ov=%b res=%h z=%b ill=%b, exp ov=1 res=0 z=1 ill=1",
                 codes[i], out_valid, result, zero, illegal);
      end
    end
    issue(3'b000, 32'h1, 32'h2);
    step();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, result, illegal} !== {1'b1, 32'h3, 1'b0}) begin
      fails++;
      $display("FAIL illegal_recover: got ov=%b res=%h ill=%b, exp ov=1 res=3 ill=0",
               out_valid, result, illegal);
    end
    step();
  endtask

`ifdef ALU_EXEC_MUL_EN
  task automatic test_mul();
    out_ready = 1'b1;
    issue(3'b100, 32'd1000, 32'd3000);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL mul_busy_%0d: got rdy=%b ov=%b, exp rdy=0 ov=0", i, in_ready, out_valid);
      end
      step();
    end
    tests++;
    if ({out_valid, result, zero, illegal, in_ready} !== {1'b1, 32'd3_000_000, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL mul_result: got ov=%b res=%0d z=%b ill=%b rdy=%b, exp ov=1 res=3000000 z=0 ill=0 rdy=1",
               out_valid, result, zero, illegal, in_ready);
    end
    step();
  endtask

  task automatic test_mul_reset();
    int seen = 0;
    out_ready = 1'b1;
    issue(3'b100, 32'd1000, 32'd3000);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mul_rst_ready: got in_ready=%b exp 1", in_ready);
    end
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) seen++;
      step();
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL mul_rst_no_output: got %0d out_valid cycles, exp 0", seen);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_add();
    test_sub_slt();
    test_back_to_back();
    test_backpressure();
    test_illegal();
`ifdef ALU_EXEC_MUL_EN
    test_mul();
    test_mul_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
